// File: rtl/addr_sequencer_if.sv
// Bus bundle between the 6502 addressing/timing sequencer and the control logic.
// master: the sequencer (drives timing and decode outputs).
// slave:  the control/execute logic that feeds it.
interface addr_sequencer_if #(
   parameter int EXEC_W = 3
);
   logic              ready;
   logic [7:0]        data_in;
   logic              alu_carry_out;
   logic              exec_done;
   logic [1:0]        phase;
   logic [1:0]        state;
   logic [EXEC_W-1:0] exec_step;
   logic [7:0]        opcode;
   logic [3:0]        mode;
   logic              is_store_acc;
   logic              is_store_x;
   logic              is_store_y;
   logic              carry_to_high_op;
   logic              sync;

   modport master (
      input  ready, data_in, alu_carry_out, exec_done,
      output phase, state, exec_step, opcode, mode,
             is_store_acc, is_store_x, is_store_y, carry_to_high_op, sync
   );

   modport slave (
      output ready, data_in, alu_carry_out, exec_done,
      input  phase, state, exec_step, opcode, mode,
             is_store_acc, is_store_x, is_store_y, carry_to_high_op, sync
   );
endinterface

// File: rtl/addr_sequencer.sv
// 6502 timing/state generator: latches the opcode, decodes addressing mode and
// store class, steps the addressing states A0..A3, then counts execute cycles
// until the execute logic reports completion. Also holds the low-byte carry
// used to fix up the high address byte for indexed/indirect-indexed modes.
module addr_sequencer #(
   parameter logic [7:0] RESET_OPCODE = 8'hEA,
   parameter int         EXEC_W       = 3
) (
   input  logic             clk,
   input  logic             nrst,
   addr_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      PH_FETCH = 2'd0,
      PH_ADDR  = 2'd1,
      PH_EXEC  = 2'd2
   } phase_t;

   typedef enum logic [3:0] {
      M_IMPL  = 4'd0,
      M_IMM   = 4'd1,
      M_ZPG   = 4'd2,
      M_ZPG_X = 4'd3,
      M_ZPG_Y = 4'd4,
      M_ABS   = 4'd5,
      M_ABS_X = 4'd6,
      M_ABS_Y = 4'd7,
      M_IND_X = 4'd8,
      M_IND_Y = 4'd9
   } mode_t;

   function automatic mode_t decode_mode(input logic [7:0] op);
      logic [1:0] cc;
      logic [2:0] bbb;
      logic [2:0] aaa;
      mode_t      m;
      cc  = op[1:0];
      bbb = op[4:2];
      aaa = op[7:5];
      m   = M_IMPL;
      case (cc)
         2'b01: begin
            case (bbb)
               3'd0:    m = M_IND_X;
               3'd1:    m = M_ZPG;
               3'd2:    m = M_IMM;
               3'd3:    m = M_ABS;
               3'd4:    m = M_IND_Y;
               3'd5:    m = M_ZPG_X;
               3'd6:    m = M_ABS_Y;
               default: m = M_ABS_X;
            endcase
         end
         2'b10: begin
            case (bbb)
               3'd0:    m = (aaa == 3'b101) ? M_IMM : M_IMPL;
               3'd1:    m = M_ZPG;
               3'd3:    m = M_ABS;
               3'd5:    m = (aaa == 3'b100 || aaa == 3'b101) ? M_ZPG_Y : M_ZPG_X;
               3'd7:    m = (aaa == 3'b101) ? M_ABS_Y : M_ABS_X;
               default: m = M_IMPL;
            endcase
         end
         2'b00: begin
            case (bbb)
               3'd0:    m = (aaa >= 3'b101) ? M_IMM : M_IMPL;
               3'd1:    m = M_ZPG;
               3'd3:    m = M_ABS;
               3'd5:    m = M_ZPG_X;
               3'd7:    m = M_ABS_X;
               default: m = M_IMPL;
            endcase
         end
         default: m = M_IMPL;
      endcase
      return m;
   endfunction

   // Number of addressing states for a mode (0 means skip ADDR entirely).
   function automatic logic [2:0] addr_count(input mode_t m);
      logic [2:0] n;
      case (m)
         M_ZPG:                      n = 3'd1;
         M_ZPG_X, M_ZPG_Y, M_ABS:    n = 3'd2;
         M_ABS_X, M_ABS_Y:           n = 3'd3;
         M_IND_X, M_IND_Y:           n = 3'd4;
         default:                    n = 3'd0;
      endcase
      return n;
   endfunction

   phase_t            phase_q;
   logic [1:0]        state_q;
   logic [EXEC_W-1:0] step_q;
   logic [7:0]        opcode_q;
   logic              carry_q;
   logic              sync_q;

   mode_t      cur_mode;
   mode_t      fetch_mode;
   logic [2:0] cur_count;
   logic [1:0] cur_last;
   logic       capture_mode;

   assign cur_mode     = decode_mode(opcode_q);
   assign fetch_mode   = decode_mode(bus.data_in);
   assign cur_count    = addr_count(cur_mode);
   assign cur_last     = 2'(cur_count - 3'd1);
   assign capture_mode = (cur_mode == M_ABS_X) || (cur_mode == M_ABS_Y) || (cur_mode == M_IND_Y);

   // Phase/state/step sequencing, opcode latch and carry capture; RDY freezes all.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         phase_q  <= PH_FETCH;
         state_q  <= '0;
         step_q   <= '0;
         opcode_q <= RESET_OPCODE;
         carry_q  <= 1'b0;
         sync_q   <= 1'b1;
      end else if (bus.ready) begin
         case (phase_q)
            PH_FETCH: begin
               opcode_q <= bus.data_in;
               carry_q  <= 1'b0;
               state_q  <= '0;
               step_q   <= '0;
               sync_q   <= 1'b0;
               // Branch on the byte being latched, not the stale opcode register.
               if (addr_count(fetch_mode) != 3'd0) begin
                  phase_q <= PH_ADDR;
               end else begin
                  phase_q <= PH_EXEC;
               end
            end
            PH_ADDR: begin
               if (state_q == 2'd1 && capture_mode) begin
                  carry_q <= bus.alu_carry_out;
               end
               if (state_q != cur_last) begin
                  state_q <= state_q + 2'd1;
               end else begin
                  phase_q <= PH_EXEC;
                  state_q <= '0;
                  step_q  <= '0;
               end
            end
            PH_EXEC: begin
               if (bus.exec_done) begin
                  phase_q <= PH_FETCH;
                  step_q  <= '0;
                  sync_q  <= 1'b1;
               end else if (step_q != '1) begin
                  step_q <= step_q + 1'b1;
               end
            end
            default: begin
               phase_q <= PH_FETCH;
               state_q <= '0;
               step_q  <= '0;
               sync_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.phase            = phase_q;
   assign bus.state            = state_q;
   assign bus.exec_step        = step_q;
   assign bus.opcode           = opcode_q;
   assign bus.carry_to_high_op = carry_q;
   assign bus.sync             = sync_q;
   assign bus.mode             = cur_mode;
   assign bus.is_store_acc     = (opcode_q[1:0] == 2'b01) && (opcode_q[7:5] == 3'b100) &&
                                 (cur_mode != M_IMM);
   assign bus.is_store_x       = (opcode_q == 8'h86) || (opcode_q == 8'h8E) || (opcode_q == 8'h96);
   assign bus.is_store_y       = (opcode_q == 8'h84) || (opcode_q == 8'h8C) || (opcode_q == 8'h94);

endmodule

// File: tb/tb_addr_sequencer.sv
// Bench for addr_sequencer: directed instruction scenarios followed by random
// opcodes, execute lengths, carries and RDY stalls, all checked against an
// instruction-level expectation (cycle index within the instruction).
module tb_addr_sequencer;

   logic clk;
   logic nrst;
   int   total;
   int   bad;

   logic [7:0] cur_op;
   logic       carry_exp;

   addr_sequencer_if #(.EXEC_W(3)) bus ();

   addr_sequencer #(.RESET_OPCODE(8'hEA), .EXEC_W(3)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Addressing mode as listed in the opcode map rules.
   function automatic int ref_mode(input logic [7:0] op);
      int cc;
      int bbb;
      int aaa;
      int modes01 [8];
      cc  = int'(op) % 4;
      bbb = (int'(op) / 4) % 8;
      aaa = int'(op) / 32;
      modes01 = '{8, 2, 1, 5, 9, 3, 7, 6};
      if (cc == 1) return modes01[bbb];
      if (cc == 2) begin
         if (bbb == 0) return (aaa == 5) ? 1 : 0;
         if (bbb == 1) return 2;
         if (bbb == 3) return 5;
         if (bbb == 5) return (aaa == 4 || aaa == 5) ? 4 : 3;
         if (bbb == 7) return (aaa == 5) ? 7 : 6;
         return 0;
      end
      if (cc == 0) begin
         if (bbb == 0) return (aaa >= 5) ? 1 : 0;
         if (bbb == 1) return 2;
         if (bbb == 3) return 5;
         if (bbb == 5) return 3;
         if (bbb == 7) return 6;
         return 0;
      end
      return 0;
   endfunction

   function automatic int ref_count(input int m);
      int tab [10];
      tab = '{0, 0, 1, 2, 2, 2, 3, 3, 4, 4};
      return tab[m];
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the expected phase/state/step plus the model's opcode and carry.
   task automatic check_outputs(input int ph, input int st, input int stp);
      int m;
      m = ref_mode(cur_op);
      chk("phase",     16'(bus.phase),            16'(ph));
      chk("state",     16'(bus.state),            16'(st));
      chk("exec_step", 16'(bus.exec_step),        16'(stp));
      chk("opcode",    16'(bus.opcode),           16'(cur_op));
      chk("mode",      16'(bus.mode),             16'(m));
      chk("store_acc", 16'(bus.is_store_acc),     16'(cur_op[1:0] == 2'b01 && cur_op[7:5] == 3'b100 && m != 1));
      chk("store_x",   16'(bus.is_store_x),       16'(cur_op == 8'h86 || cur_op == 8'h8E || cur_op == 8'h96));
      chk("store_y",   16'(bus.is_store_y),       16'(cur_op == 8'h84 || cur_op == 8'h8C || cur_op == 8'h94));
      chk("carry",     16'(bus.carry_to_high_op), 16'(carry_exp));
      chk("sync",      16'(bus.sync),             16'(ph == 0));
   endtask

   // Run one instruction from its FETCH cycle; called at a negedge, returns at the
   // negedge where the next FETCH cycle is visible. Cycle index k: 0 = FETCH,
   // 1..cnt = A0.., then execute steps. exec_len = cycles with exec_done low before it rises.
   task automatic run_instr(input logic [7:0] op, input int exec_len, input logic cap,
                            input bit rnd, input int stall_k, input int stall_n);
      int   cnt;
      int   last_k;
      int   k;
      int   stalls;
      int   ph;
      int   st;
      int   stp;
      bit   go;
      bit   capk;
      int   m_new;
      m_new  = ref_mode(op);
      cnt    = ref_count(m_new);
      last_k = 1 + cnt + exec_len;
      k      = 0;
      stalls = 0;
      while (k <= last_k) begin
         if (k == 0) begin
            ph = 0; st = 0; stp = 0;
         end else if (k <= cnt) begin
            ph = 1; st = k - 1; stp = 0;
         end else begin
            ph = 2; st = 0; stp = (k - 1 - cnt > 7) ? 7 : k - 1 - cnt;
         end
         check_outputs(ph, st, stp);

         go = 1'b1;
         if (k == stall_k && stalls < stall_n) begin
            go = 1'b0;
            stalls++;
         end else if (rnd && $urandom_range(3) == 0) begin
            go = 1'b0;
         end
         capk = (k == 2) && (m_new == 6 || m_new == 7 || m_new == 9);
         bus.ready         = go;
         bus.data_in       = (k == 0 && go) ? op : 8'($urandom);
         bus.alu_carry_out = (capk && go) ? cap : ~cap;
         if (k == last_k)  bus.exec_done = 1'b1;
         else if (k <= cnt) bus.exec_done = rnd ? 1'($urandom) : 1'b1;
         else               bus.exec_done = 1'b0;

         @(negedge clk);
         if (go) begin
            if (k == 0) begin
               cur_op    = op;
               carry_exp = 1'b0;
            end
            if (capk) carry_exp = cap;
            k++;
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cur_op    = 8'hEA;
      carry_exp = 1'b0;
      nrst              = 1'b0;
      bus.ready         = 1'b1;
      bus.data_in       = 8'h00;
      bus.alu_carry_out = 1'b0;
      bus.exec_done     = 1'b0;
      repeat (3) @(negedge clk);

      // Start INX and reset it in the middle of EXEC with RDY low.
      nrst        = 1'b1;
      bus.data_in = 8'hE8;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_phase", 16'(bus.phase),     16'd2);
      chk("pre_rst_step",  16'(bus.exec_step), 16'd1);
      nrst          = 1'b0;
      bus.ready     = 1'b0;
      bus.exec_done = 1'b1;
      repeat (2) @(negedge clk);
      nrst      = 1'b1;
      cur_op    = 8'hEA;
      carry_exp = 1'b0;
      check_outputs(0, 0, 0);

      // LDA zp, one-cycle execute.
      run_instr(8'hA5, 0, 1'b0, 1'b0, -1, 0);
      // STA (zp),Y with carry captured at A1, then cleared by the following FETCH.
      run_instr(8'h91, 1, 1'b1, 1'b0, -1, 0);
      run_instr(8'hBE, 0, 1'b1, 1'b0, -1, 0);
      run_instr(8'hB6, 1, 1'b0, 1'b0, -1, 0);
      run_instr(8'h96, 0, 1'b0, 1'b0, -1, 0);
      // STA abs with RDY low for three cycles at A1.
      run_instr(8'h8D, 0, 1'b1, 1'b0, 2, 3);
      // INX: direct to EXEC, step saturates at 7.
      run_instr(8'hE8, 10, 1'b0, 1'b0, -1, 0);
      run_instr(8'h7D, 2, 1'b1, 1'b0, 0, 2);
      run_instr(8'h89, 0, 1'b0, 1'b0, -1, 0);

      for (int i = 0; i < 60; i++) begin
         run_instr(8'($urandom), int'($urandom_range(9)), 1'($urandom), 1'b1, -1, 0);
      end
      check_outputs(0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
